ml_kl_arbiter: RTL
==================

Name: ml_kl_arbiter

Overview:
- Shares the single KLink generic TX/RX port of the MLink transceiver between two requesters: port 0 (I-side) and port 1 (D-side).
- TX side: arbitrates requests, locks the grant for the full data burst, and tags the source ID with the port index.
- RX side: demultiplexes responses back to the originating port by ID.
- Tracks outstanding transactions per port and throttles a port at a configurable limit.

Parameters:
- MAX_OUTSTANDING, 4: max in-flight requests per port, range 1..15.
- BEAT_CNT_WIDTH, 5: width of the TX/RX burst beat counters; must hold 16.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- m0_tx_addr/m1_tx_addr  in  32  request address
- m0_tx_den/m1_tx_den  in  1  request carries data
- m0_tx_data/m1_tx_data  in  64  request data beat
- m0_tx_size/m1_tx_size  in  3  log2 bytes
- m0_tx_id/m1_tx_id  in  4  requester-local ID
- m0_tx_valid/m1_tx_valid  in  1  request beat valid
- m0_tx_ready/m1_tx_ready  out  1  request beat accepted
- m0_rx_addr/m1_rx_addr  out  32  response address
- m0_rx_data/m1_rx_data  out  64  response data beat
- m0_rx_den/m1_rx_den  out  1  response carries data
- m0_rx_size/m1_rx_size  out  3  response size
- m0_rx_id/m1_rx_id  out  4  requester-local ID
- m0_rx_valid/m1_rx_valid  out  1  response beat valid
- m0_rx_ready/m1_rx_ready  in  1  response beat taken
- kl_tx_addr, kl_tx_den, kl_tx_data, kl_tx_size  out  32/1/64/3  to transceiver
- kl_tx_id  out  5  {port index, local id}
- kl_tx_valid  out  1
- kl_tx_ready  in  1
- kl_rx_addr, kl_rx_data, kl_rx_den, kl_rx_size, kl_rx_id, kl_rx_valid  in  32/64/1/3/5/1  from transceiver
- kl_rx_ready  out  1
- os_cnt0/os_cnt1  out  4  outstanding count per port, debug

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. Reset values:
  - state = ST_IDLE.
  - last_grant = 1, so port 0 wins the first tie.
  - os_cnt0/os_cnt1 = 0, both beat counters = 0.
  - All *_tx_ready and *_rx_valid deassert combinationally while state is IDLE with no valid input.
- Beats per transaction: beats = den ? max(1, (1<<size)/8) : 1. Sizes 0..3 give 1 beat; size 7 gives 16 beats.
- Eligibility: port p is eligible when mp_tx_valid = 1 and os_cntp < MAX_OUTSTANDING.
- ST_IDLE grant (combinational, no added latency):
  - One eligible port: that port is granted.
  - Both eligible: the port != last_grant is granted (round-robin).
  - Granted port's signals are muxed to kl_tx_*; mp_tx_ready = kl_tx_ready; the other port's ready = 0.
  - kl_tx_id = {p, mp_tx_id}.
- On a first-beat handshake (kl_tx_valid & kl_tx_ready):
  - last_grant <= p; os_cntp increments.
  - If beats > 1: tx_cnt <= beats-1, lock_port <= p, go to ST_TX_LOCK. Otherwise stay in ST_IDLE.
- ST_TX_LOCK:
  - Only lock_port is muxed and can be readied; the other port sees ready = 0 even if eligible.
  - Each handshake decrements tx_cnt. The handshake with tx_cnt == 1 returns to ST_IDLE.
  - Outstanding limit is not rechecked mid-burst.
- RX routing (combinational):
  - Destination = kl_rx_id[4].
  - mp_rx_valid = kl_rx_valid & (kl_rx_id[4] == p); mp_rx_id = kl_rx_id[3:0]; other fields are broadcast.
  - kl_rx_ready = ready of the destination port.
- RX beat counting:
  - rx_cnt counts handshakes. The response ends on the handshake where rx_cnt + 1 == beats(kl_rx_den, kl_rx_size); rx_cnt then resets to 0.
  - At response end: os_cnt of the destination port decrements.
- Same port increments and decrements in the same cycle: count unchanged.
- Decrement at 0 is an error: count saturates at 0. Under SIMULATION, $display an error.
- Increment never exceeds MAX_OUTSTANDING, because eligibility gating prevents it.
- TX and RX sides are fully independent; both may handshake in the same cycle.

Optional Feature:
- Macro: ML_ARB_FIXED_PRIO_EN.
- Defined: port 1 (D-side) always wins when both ports are eligible in ST_IDLE; last_grant is unused. Burst lock and outstanding limits are unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Both ports valid after reset, size 3, den = 0, kl_tx_ready = 1:
  - Cycle 1 grants port 0, kl_tx_id = {0, id0}.
  - Cycle 2 grants port 1, kl_tx_id = {1, id1}.
  - With ML_ARB_FIXED_PRIO_EN: port 1 is granted first.
- Port 0 issues size 6, den = 1 (8 beats); port 1 asserts valid on beat 2:
  - m1_tx_ready stays 0 for all 8 beats.
  - Port 1 is granted the cycle after port 0's 8th beat.
- MAX_OUTSTANDING = 2, port 0 issues 3 dataless requests with no responses:
  - Third request is held with m0_tx_ready = 0; os_cnt0 = 2.
  - One response with kl_rx_id = 5'h03 returns → os_cnt0 = 1 and the third request is accepted.
- RX response kl_rx_id = 5'h1A, den = 1, size 5 (4 beats), m1_rx_ready toggling:
  - m1_rx_valid follows kl_rx_valid; m0_rx_valid = 0; m1_rx_id = 4'hA.
  - os_cnt1 decrements only on the 4th handshake.
- Same cycle: port 1 first-beat handshake and last RX beat for port 1 → os_cnt1 unchanged.
- rst asserted mid 16-beat burst (size 7) at beat 5:
  - Next cycle: state = IDLE, os_cnt0 = os_cnt1 = 0.
  - Port 0 wins the first tie afterwards.

Source files
------------

// File: rtl/ml_kl_arbiter.sv
// Two-port arbiter sharing one KLink TX/RX port: burst-locked TX grant with ID tagging,
// RX demux by ID bit 4, per-port outstanding throttling. Optional macro ML_ARB_FIXED_PRIO_EN.
module ml_kl_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int BEAT_CNT_WIDTH  = 5
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] m0_tx_addr,
    input  logic        m0_tx_den,
    input  logic [63:0] m0_tx_data,
    input  logic [2:0]  m0_tx_size,
    input  logic [3:0]  m0_tx_id,
    input  logic        m0_tx_valid,
    output logic        m0_tx_ready,

    input  logic [31:0] m1_tx_addr,
    input  logic        m1_tx_den,
    input  logic [63:0] m1_tx_data,
    input  logic [2:0]  m1_tx_size,
    input  logic [3:0]  m1_tx_id,
    input  logic        m1_tx_valid,
    output logic        m1_tx_ready,

    output logic [31:0] m0_rx_addr,
    output logic [63:0] m0_rx_data,
    output logic        m0_rx_den,
    output logic [2:0]  m0_rx_size,
    output logic [3:0]  m0_rx_id,
    output logic        m0_rx_valid,
    input  logic        m0_rx_ready,

    output logic [31:0] m1_rx_addr,
    output logic [63:0] m1_rx_data,
    output logic        m1_rx_den,
    output logic [2:0]  m1_rx_size,
    output logic [3:0]  m1_rx_id,
    output logic        m1_rx_valid,
    input  logic        m1_rx_ready,

    output logic [31:0] kl_tx_addr,
    output logic        kl_tx_den,
    output logic [63:0] kl_tx_data,
    output logic [2:0]  kl_tx_size,
    output logic [4:0]  kl_tx_id,
    output logic        kl_tx_valid,
    input  logic        kl_tx_ready,

    input  logic [31:0] kl_rx_addr,
    input  logic [63:0] kl_rx_data,
    input  logic        kl_rx_den,
    input  logic [2:0]  kl_rx_size,
    input  logic [4:0]  kl_rx_id,
    input  logic        kl_rx_valid,
    output logic        kl_rx_ready,

    output logic [3:0]  os_cnt0,
    output logic [3:0]  os_cnt1
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_TX_LOCK = 1'b1
    } state_t;

    localparam logic [3:0]                OS_MAX   = 4'(MAX_OUTSTANDING);
    localparam logic [BEAT_CNT_WIDTH-1:0] BEAT_ONE = BEAT_CNT_WIDTH'(1);
    localparam logic [BEAT_CNT_WIDTH-1:0] BEAT_ZERO = BEAT_CNT_WIDTH'(0);

    // Dataless transfers and transfers up to 8 bytes occupy one beat of the 64-bit bus.
    function automatic logic [BEAT_CNT_WIDTH-1:0] beats_of(input logic den, input logic [2:0] size);
        logic [BEAT_CNT_WIDTH-1:0] n;
        n = BEAT_ONE;
        if (den) begin
            case (size)
                3'd4:    n = BEAT_CNT_WIDTH'(2);
                3'd5:    n = BEAT_CNT_WIDTH'(4);
                3'd6:    n = BEAT_CNT_WIDTH'(8);
                3'd7:    n = BEAT_CNT_WIDTH'(16);
                default: n = BEAT_ONE;
            endcase
        end else begin
            n = BEAT_ONE;
        end
        return n;
    endfunction

    // A simultaneous increment and decrement cancel; a decrement at zero saturates.
    function automatic logic [3:0] os_next(input logic [3:0] cnt, input logic inc, input logic dec);
        logic [3:0] n;
        case ({inc, dec})
            2'b10:   n = cnt + 4'd1;
            2'b01:   n = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
            default: n = cnt;
        endcase
        return n;
    endfunction

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic                      last_grant_r;
    logic                      lock_port_r;
    logic [BEAT_CNT_WIDTH-1:0] tx_cnt_r;
    logic [BEAT_CNT_WIDTH-1:0] rx_cnt_r;
    logic [3:0]                os_cnt0_r;
    logic [3:0]                os_cnt1_r;

    logic                      elig0_s;
    logic                      elig1_s;
    logic                      gnt_valid_s;
    logic                      gnt_port_s;
    logic                      tx_hs_s;
    logic                      first_hs_s;
    logic [BEAT_CNT_WIDTH-1:0] tx_beats_s;
    logic                      rx_dest_s;
    logic                      rx_hs_s;
    logic                      rx_last_s;
    logic [BEAT_CNT_WIDTH-1:0] rx_beats_s;
    logic                      inc0_s;
    logic                      inc1_s;
    logic                      dec0_s;
    logic                      dec1_s;

    assign elig0_s = m0_tx_valid && (os_cnt0_r < OS_MAX);
    assign elig1_s = m1_tx_valid && (os_cnt1_r < OS_MAX);

    // Grant selection: burst lock overrides arbitration; the limit is only checked at burst start.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_port_s  = 1'b0;
        if (state_r == ST_TX_LOCK) begin
            gnt_valid_s = 1'b1;
            gnt_port_s  = lock_port_r;
        end else if (elig0_s && elig1_s) begin
            gnt_valid_s = 1'b1;
`ifdef ML_ARB_FIXED_PRIO_EN
            gnt_port_s  = 1'b1;
`else
            gnt_port_s  = ~last_grant_r;
`endif
        end else if (elig0_s) begin
            gnt_valid_s = 1'b1;
            gnt_port_s  = 1'b0;
        end else if (elig1_s) begin
            gnt_valid_s = 1'b1;
            gnt_port_s  = 1'b1;
        end else begin
            gnt_valid_s = 1'b0;
            gnt_port_s  = 1'b0;
        end
    end

    // TX request mux toward the transceiver and ready steering back to the requesters.
    always_comb begin
        kl_tx_addr  = m0_tx_addr;
        kl_tx_den   = m0_tx_den;
        kl_tx_data  = m0_tx_data;
        kl_tx_size  = m0_tx_size;
        kl_tx_id    = {1'b0, m0_tx_id};
        kl_tx_valid = 1'b0;
        m0_tx_ready = 1'b0;
        m1_tx_ready = 1'b0;
        if (gnt_port_s) begin
            kl_tx_addr  = m1_tx_addr;
            kl_tx_den   = m1_tx_den;
            kl_tx_data  = m1_tx_data;
            kl_tx_size  = m1_tx_size;
            kl_tx_id    = {1'b1, m1_tx_id};
            kl_tx_valid = gnt_valid_s && m1_tx_valid;
            m1_tx_ready = gnt_valid_s && kl_tx_ready;
        end else begin
            kl_tx_valid = gnt_valid_s && m0_tx_valid;
            m0_tx_ready = gnt_valid_s && kl_tx_ready;
        end
    end

    assign tx_hs_s    = kl_tx_valid && kl_tx_ready;
    assign first_hs_s = tx_hs_s && (state_r == ST_IDLE);
    assign tx_beats_s = beats_of(kl_tx_den, kl_tx_size);
    assign inc0_s     = first_hs_s && !gnt_port_s;
    assign inc1_s     = first_hs_s && gnt_port_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: a multi-beat first handshake locks; the handshake at tx_cnt == 1 unlocks.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (first_hs_s && (tx_beats_s > BEAT_ONE)) begin
                    state_nxt_s = ST_TX_LOCK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_TX_LOCK: begin
                if (tx_hs_s && (tx_cnt_r == BEAT_ONE)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_TX_LOCK;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // TX burst bookkeeping: round-robin history, lock owner and remaining beat count.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 1'b1;
            lock_port_r  <= 1'b0;
            tx_cnt_r     <= BEAT_ZERO;
        end else if (first_hs_s) begin
            last_grant_r <= gnt_port_s;
            lock_port_r  <= gnt_port_s;
            tx_cnt_r     <= (tx_beats_s > BEAT_ONE) ? (tx_beats_s - BEAT_ONE) : BEAT_ZERO;
        end else if (tx_hs_s && (state_r == ST_TX_LOCK)) begin
            tx_cnt_r     <= tx_cnt_r - BEAT_ONE;
        end else begin
            tx_cnt_r     <= tx_cnt_r;
        end
    end

    // RX demux: bit 4 of the returned ID selects the requester; payload is broadcast.
    always_comb begin
        rx_dest_s   = kl_rx_id[4];
        m0_rx_addr  = kl_rx_addr;
        m0_rx_data  = kl_rx_data;
        m0_rx_den   = kl_rx_den;
        m0_rx_size  = kl_rx_size;
        m0_rx_id    = kl_rx_id[3:0];
        m0_rx_valid = kl_rx_valid && !rx_dest_s;
        m1_rx_addr  = kl_rx_addr;
        m1_rx_data  = kl_rx_data;
        m1_rx_den   = kl_rx_den;
        m1_rx_size  = kl_rx_size;
        m1_rx_id    = kl_rx_id[3:0];
        m1_rx_valid = kl_rx_valid && rx_dest_s;
        if (rx_dest_s) begin
            kl_rx_ready = m1_rx_ready;
        end else begin
            kl_rx_ready = m0_rx_ready;
        end
    end

    assign rx_hs_s    = kl_rx_valid && kl_rx_ready;
    assign rx_beats_s = beats_of(kl_rx_den, kl_rx_size);
    assign rx_last_s  = rx_hs_s && ((rx_cnt_r + BEAT_ONE) == rx_beats_s);
    assign dec0_s     = rx_last_s && !rx_dest_s;
    assign dec1_s     = rx_last_s && rx_dest_s;

    // RX beat counter, cleared on the final beat of each response.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt_r <= BEAT_ZERO;
        end else if (rx_last_s) begin
            rx_cnt_r <= BEAT_ZERO;
        end else if (rx_hs_s) begin
            rx_cnt_r <= rx_cnt_r + BEAT_ONE;
        end else begin
            rx_cnt_r <= rx_cnt_r;
        end
    end

    // Outstanding counters per port.
    always_ff @(posedge clk) begin
        if (rst) begin
            os_cnt0_r <= 4'd0;
            os_cnt1_r <= 4'd0;
        end else begin
            os_cnt0_r <= os_next(os_cnt0_r, inc0_s, dec0_s);
            os_cnt1_r <= os_next(os_cnt1_r, inc1_s, dec1_s);
        end
    end

`ifdef SIMULATION
    // Report responses arriving for a port with nothing outstanding.
    always_ff @(posedge clk) begin
        if (!rst && dec0_s && !inc0_s && (os_cnt0_r == 4'd0)) begin
            $display("ml_kl_arbiter: error, response for port 0 with no outstanding request");
        end else if (!rst && dec1_s && !inc1_s && (os_cnt1_r == 4'd0)) begin
            $display("ml_kl_arbiter: error, response for port 1 with no outstanding request");
        end else begin
        end
    end
`endif

    assign os_cnt0 = os_cnt0_r;
    assign os_cnt1 = os_cnt1_r;

endmodule
